// File: rtl/delay_sched.sv
// rtl/delay_sched.sv - three-channel sample delay line sharing one storage array
// Round-robin arbiter grants one channel per cycle; each channel fills before emitting.
module delay_sched #(
  parameter int DW  = 12,
  parameter int AW  = 7,
  parameter int NCH = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] in_valid,
  input  logic [DW-1:0]  in_data0,
  input  logic [DW-1:0]  in_data1,
  input  logic [DW-1:0]  in_data2,
  output logic [NCH-1:0] in_ready,
  input  logic           cfg_we,
  input  logic [1:0]     cfg_ch,
  input  logic [AW-1:0]  cfg_dly,
  output logic           out_valid,
  output logic [1:0]     out_ch,
  output logic [DW-1:0]  out_data,
  output logic [NCH-1:0] fill_busy
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {FILL = 1'b0, RUN = 1'b1} ch_state_t;

  logic [DW-1:0] mem [0:NCH*DEPTH-1];

  logic [AW-1:0] wptr     [NCH];
  logic [AW-1:0] fill_cnt [NCH];
  logic [AW-1:0] dly      [NCH];
  ch_state_t     state    [NCH];
  logic [1:0]    rr_ptr;

  logic [NCH-1:0] cfg_hit;
  logic [NCH-1:0] elig;
  logic [NCH-1:0] gnt;
  logic [1:0]     gnt_ch;
  logic [DW-1:0]  gnt_data;
  logic [AW-1:0]  gnt_wptr;
  logic [AW-1:0]  gnt_dly;
  logic           gnt_run;
  logic [AW-1:0]  rd_idx;
  logic [AW-1:0]  cfg_dly_eff;
  logic [AW+1:0]  waddr;
  logic [AW+1:0]  raddr;

  // A channel being reconfigured sits out arbitration for that cycle.
  assign cfg_hit     = (cfg_we && cfg_ch != 2'd3) ? (3'b001 << cfg_ch) : 3'b000;
  assign elig        = in_valid & ~cfg_hit & {NCH{~reset}};
  assign cfg_dly_eff = (cfg_dly == '0) ? AW'(1) : cfg_dly;

  always_comb begin
    gnt = '0;
    case (rr_ptr)
      2'd0: begin
        if      (elig[0]) gnt = 3'b001;
        else if (elig[1]) gnt = 3'b010;
        else if (elig[2]) gnt = 3'b100;
      end
      2'd1: begin
        if      (elig[1]) gnt = 3'b010;
        else if (elig[2]) gnt = 3'b100;
        else if (elig[0]) gnt = 3'b001;
      end
      default: begin
        if      (elig[2]) gnt = 3'b100;
        else if (elig[0]) gnt = 3'b001;
        else if (elig[1]) gnt = 3'b010;
      end
    endcase
  end

  assign in_ready = gnt;

  always_comb begin
    gnt_ch = 2'd0;
    if (gnt[1]) gnt_ch = 2'd1;
    if (gnt[2]) gnt_ch = 2'd2;
  end

  always_comb begin
    gnt_data = in_data0;
    gnt_wptr = wptr[0];
    gnt_dly  = dly[0];
    gnt_run  = (state[0] == RUN);
    case (gnt_ch)
      2'd1: begin
        gnt_data = in_data1;
        gnt_wptr = wptr[1];
        gnt_dly  = dly[1];
        gnt_run  = (state[1] == RUN);
      end
      2'd2: begin
        gnt_data = in_data2;
        gnt_wptr = wptr[2];
        gnt_dly  = dly[2];
        gnt_run  = (state[2] == RUN);
      end
      default: ;
    endcase
  end

  // Read and write slots never collide because the delay is at least 1.
  assign rd_idx = gnt_wptr - gnt_dly;
  assign waddr  = {gnt_ch, gnt_wptr};
  assign raddr  = {gnt_ch, rd_idx};

  always_ff @(posedge clk) begin
    if (|gnt) begin
      mem[waddr] <= gnt_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= 2'd0;
      out_valid <= 1'b0;
      out_ch    <= 2'd0;
      out_data  <= '0;
      for (int n = 0; n < NCH; n++) begin
        wptr[n]     <= '0;
        fill_cnt[n] <= '0;
        dly[n]      <= AW'(104);
        state[n]    <= FILL;
      end
    end else begin
      out_valid <= 1'b0;
      if (|gnt) begin
        rr_ptr <= (gnt_ch == 2'd2) ? 2'd0 : gnt_ch + 2'd1;
        if (gnt_run) begin
          out_valid <= 1'b1;
          out_ch    <= gnt_ch;
          out_data  <= mem[raddr];
        end
      end
      for (int n = 0; n < NCH; n++) begin
        if (gnt[n]) begin
          wptr[n] <= wptr[n] + AW'(1);
          if (state[n] == FILL) begin
            fill_cnt[n] <= fill_cnt[n] + AW'(1);
            if (fill_cnt[n] + AW'(1) == dly[n]) begin
              state[n] <= RUN;
            end
          end
        end
        if (cfg_hit[n]) begin
          dly[n]      <= cfg_dly_eff;
          fill_cnt[n] <= '0;
          state[n]    <= FILL;
        end
      end
    end
  end

  always_comb begin
    fill_busy = '0;
    for (int n = 0; n < NCH; n++) begin
      fill_busy[n] = (state[n] == FILL);
    end
  end

endmodule

// File: tb/tb_delay_sched.sv
// tb/tb_delay_sched.sv - self-checking bench for delay_sched
// Per-channel sample history model plus directed literal checks.
module tb_delay_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  in_valid = 3'b000;
  logic [11:0] in_data0 = '0;
  logic [11:0] in_data1 = '0;
  logic [11:0] in_data2 = '0;
  logic [2:0]  in_ready;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = 2'd0;
  logic [6:0]  cfg_dly = '0;
  logic        out_valid;
  logic [1:0]  out_ch;
  logic [11:0] out_data;
  logic [2:0]  fill_busy;

  delay_sched dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2),
    .in_ready(in_ready), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_dly(cfg_dly),
    .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data), .fill_busy(fill_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each channel keeps the samples accepted since its last reset/config.
  int         m_cnt [3];
  int         m_dly [3];
  int         m_last;
  int         hist  [3][512];
  logic [2:0] mdl_gnt = 3'b000;
  logic       exp_valid;
  logic [1:0] exp_ch;
  int         exp_data;
  logic [2:0] exp_fill;
  bit         model_on = 1'b0;

  always @(negedge clk) begin
    logic [2:0] blk;
    logic [2:0] elig;
    int c_sel;
    int c;
    int data_in [3];
    data_in[0] = int'(in_data0);
    data_in[1] = int'(in_data1);
    data_in[2] = int'(in_data2);
    blk = 3'b000;
    if (!reset && cfg_we && cfg_ch != 2'd3) blk[cfg_ch] = 1'b1;
    elig = reset ? 3'b000 : (in_valid & ~blk);
    c_sel = -1;
    for (int k = 1; k <= 3; k++) begin
      c = (m_last + k) % 3;
      if (elig[c] && c_sel < 0) c_sel = c;
    end
    mdl_gnt = (c_sel >= 0) ? (3'b001 << c_sel) : 3'b000;

    if (model_on) begin
      chk("in_ready", 32'(in_ready), 32'(mdl_gnt));
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      if (exp_valid) begin
        chk("out_ch", 32'(out_ch), 32'(exp_ch));
        chk("out_data", 32'(out_data), exp_data);
      end
      chk("fill_busy", 32'(fill_busy), 32'(exp_fill));
    end

    if (reset) begin
      for (int n = 0; n < 3; n++) begin
        m_cnt[n] = 0;
        m_dly[n] = 104;
      end
      m_last    = 2;
      exp_valid = 1'b0;
      exp_fill  = 3'b111;
      model_on  = 1'b1;
    end else begin
      exp_valid = 1'b0;
      if (c_sel >= 0) begin
        if (m_cnt[c_sel] >= m_dly[c_sel]) begin
          exp_valid = 1'b1;
          exp_ch    = 2'(c_sel);
          exp_data  = hist[c_sel][m_cnt[c_sel] - m_dly[c_sel]];
        end
        if (m_cnt[c_sel] < 512) hist[c_sel][m_cnt[c_sel]] = data_in[c_sel];
        m_cnt[c_sel]++;
        m_last = c_sel;
      end
      if (blk != 3'b000) begin
        m_cnt[cfg_ch] = 0;
        m_dly[cfg_ch] = (cfg_dly == 0) ? 1 : int'(cfg_dly);
      end
      for (int n = 0; n < 3; n++) exp_fill[n] = (m_cnt[n] < m_dly[n]);
    end
  end

  // Channel n sends n*1024 + seq[n]; seq advances once the sample is granted.
  int seq [3];

  task automatic drive_data();
    in_data0 = 12'(seq[0]);
    in_data1 = 12'(1024 + seq[1]);
    in_data2 = 12'(2048 + seq[2]);
  endtask

  task automatic step(input logic [2:0] v);
    in_valid = v;
    drive_data();
    @(posedge clk);
    for (int n = 0; n < 3; n++) if (mdl_gnt[n]) seq[n]++;
    #1;
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [6:0] d, input logic [2:0] v);
    cfg_we = 1'b1; cfg_ch = ch; cfg_dly = d;
    step(v);
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 3'b111;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    step(3'b111);
    step(3'b111);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_fill_busy", 32'(fill_busy), 32'b111);
    reset = 1'b0;
    for (int n = 0; n < 3; n++) seq[n] = 1;
    in_valid = 3'b000;
  endtask

  initial begin
    for (int n = 0; n < 3; n++) seq[n] = 1;
    do_reset();

    // Single channel with default delay 104.
    for (int k = 1; k <= 110; k++) begin
      step(3'b001);
      if (k == 1)   chk("t1_ov_k1", 32'(out_valid), 32'd0);
      if (k == 103) chk("t1_fb_k103", 32'(fill_busy), 32'b111);
      if (k == 104) begin
        chk("t1_ov_k104", 32'(out_valid), 32'd0);
        chk("t1_fb_k104", 32'(fill_busy), 32'b110);
      end
      if (k == 105) begin
        chk("t1_ov_k105", 32'(out_valid), 32'd1);
        chk("t1_od_k105", 32'(out_data), 32'd1);
      end
      if (k == 110) chk("t1_od_k110", 32'(out_data), 32'd6);
    end

    // Three channels, delay 4 each, all requesting every cycle.
    do_reset();
    cfg(2'd0, 7'd4, 3'b000);
    cfg(2'd1, 7'd4, 3'b000);
    cfg(2'd2, 7'd4, 3'b000);
    for (int i = 0; i < 32; i++) begin
      in_valid = 3'b111;
      #1;
      if (i < 3) chk("t2_rr", 32'(in_ready), 32'(3'b001 << i));
      step(3'b111);
      if (i == 11) chk("t2_ov_i11", 32'(out_valid), 32'd0);
      if (i == 12) begin
        chk("t2_ov_i12", 32'(out_valid), 32'd1);
        chk("t2_oc_i12", 32'(out_ch), 32'd0);
        chk("t2_od_i12", 32'(out_data), 32'd1);
      end
      if (i == 13) chk("t2_od_i13", 32'(out_data), 32'd1025);
    end

    // Reconfigure ch2 while running, on the cycle it would otherwise be granted.
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_dly = 7'd5;
    in_valid = 3'b111;
    #1;
    chk("t3_blocked", 32'(in_ready), 32'b001);
    step(3'b111);
    cfg_we = 1'b0;
    chk("t3_fill_busy", 32'(fill_busy), 32'b100);
    for (int i = 0; i < 30; i++) step(3'b111);

    // Zero delay request acts as delay 1.
    do_reset();
    cfg(2'd1, 7'd0, 3'b000);
    step(3'b010);
    chk("t4_ov_first", 32'(out_valid), 32'd0);
    step(3'b010);
    chk("t4_ov_second", 32'(out_valid), 32'd1);
    chk("t4_oc_second", 32'(out_ch), 32'd1);
    chk("t4_od_second", 32'(out_data), 32'd1025);

    // Maximum delay across pointer wrap; first sample carries an ignored cfg_ch=3 write.
    do_reset();
    cfg(2'd0, 7'd127, 3'b000);
    for (int k = 1; k <= 300; k++) begin
      if (k == 1) begin
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_dly = 7'd2;
        in_valid = 3'b001;
        #1;
        chk("t5_ch3_ignored", 32'(in_ready), 32'b001);
      end
      step(3'b001);
      cfg_we = 1'b0;
      if (k == 127) begin
        chk("t5_ov_k127", 32'(out_valid), 32'd0);
        chk("t5_fb_k127", 32'(fill_busy), 32'b110);
      end
      if (k == 128) chk("t5_od_k128", 32'(out_data), 32'd1);
      if (k == 300) chk("t5_od_k300", 32'(out_data), 32'd173);
    end

    // Reset in the middle of a stream, then refill with the default delay.
    reset = 1'b1;
    in_valid = 3'b001;
    #1;
    chk("t6_in_ready", 32'(in_ready), 32'd0);
    step(3'b001);
    chk("t6_ov", 32'(out_valid), 32'd0);
    chk("t6_fb", 32'(fill_busy), 32'b111);
    reset = 1'b0;
    for (int n = 0; n < 3; n++) seq[n] = 1;
    for (int k = 1; k <= 105; k++) begin
      step(3'b001);
      if (k == 104) chk("t6_ov_k104", 32'(out_valid), 32'd0);
      if (k == 105) begin
        chk("t6_ov_k105", 32'(out_valid), 32'd1);
        chk("t6_od_k105", 32'(out_data), 32'd1);
      end
    end
    in_valid = 3'b000;
    step(3'b000);
    step(3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/delay_sched.md
DELAY_SCHED -- requirements
Module: delay_sched

Interface
REQ-001 Parameter DW, default 12, sample width in bits.
REQ-002 Parameter AW, default 7, per-channel buffer address width; depth 2^AW = 128 samples.
REQ-003 Parameter NCH, fixed 3, number of requester channels.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  3  per-channel sample request; bit n = channel n.
REQ-007 in_data0, in_data1, in_data2  input  DW each  channel sample data, held stable while in_valid is high.
REQ-008 in_ready  output  3  per-channel grant; sample accepted when in_valid[n] and in_ready[n] are both high.
REQ-009 cfg_we  input  1  configuration write strobe.
REQ-010 cfg_ch  input  2  channel targeted by cfg_we; value 3 is ignored.
REQ-011 cfg_dly  input  AW  requested delay in samples of the targeted channel.
REQ-012 out_valid  output  1  delayed-sample strobe, one cycle wide.
REQ-013 out_ch  output  2  channel tag of out_data.
REQ-014 out_data  output  DW  delayed sample.
REQ-015 fill_busy  output  3  bit n high while channel n is in FILL.

Function
REQ-016 Shared storage: one internal array of NCH*2^AW entries; channel n owns region n; exactly one channel accesses storage per cycle.
REQ-017 Arbitration: round-robin among channels with in_valid high; the pointer starts after the last granted channel; after reset, priority order is 0,1,2.
REQ-018 in_ready is combinational from the arbiter; at most one bit is high per cycle; in_ready[n] is never high when in_valid[n] is low.
REQ-019 Channel n is not granted in a cycle where cfg_we=1 and cfg_ch=n.
REQ-020 Granted access: read entry wptr[n]-dly[n] (modulo 2^AW) of region n, write in_data into entry wptr[n], then wptr[n] increments modulo 2^AW; the read returns the old contents (read-before-write).
REQ-021 Effective delay is dly[n] = max(cfg_dly, 1); the delay range is 1..127 samples of that channel, independent of cycle timing.
REQ-022 Per-channel states are FILL and RUN.
REQ-023 FILL: fill_cnt[n] increments per accepted sample; outputs are suppressed; when an accepted sample makes fill_cnt[n] equal dly[n], the channel transitions to RUN after that sample.
REQ-024 RUN: every accepted sample produces out_valid=1, out_ch=n, out_data = the sample accepted dly[n] samples earlier on channel n.
REQ-025 Output latency is 1 cycle: the output registers update on the clk edge following the grant cycle; out_valid is 0 in cycles that follow no RUN grant.
REQ-026 Config write (cfg_we=1, cfg_ch<3): load dly[cfg_ch], clear fill_cnt[cfg_ch], force FILL, and leave wptr unchanged; other channels are unaffected.
REQ-027 A config write to a channel in the same cycle that another channel is granted: both take effect.
REQ-028 A config write with cfg_ch=3 has no effect.
REQ-029 No backpressure exists on the output; the sink always accepts.
REQ-030 The first dly[n] outputs after FILL must never expose stale storage contents; FILL gating guarantees this.

Reset
REQ-031 Reset behaviour on reset=1:
- wptr, fill_cnt and the arbiter pointer go to 0.
- dly[n] goes to 104.
- All channels enter FILL.
- out_valid=0, out_ch=0, out_data=0, fill_busy=3'b111.
- in_ready is 0 during reset.
REQ-032 Reset mid-operation discards all in-flight and stored samples; the storage array needs no clearing.
REQ-033 Reset dominates cfg_we in the same cycle.

Verification
REQ-034 Single channel: after reset, drive ch0 continuously with in_data0 = 1,2,3,...
- First out_valid occurs on the clk edge after the grant of sample 105.
- That output is out_ch=0, out_data=1.
- Thereafter one output per cycle, incrementing; fill_busy[0] falls after sample 104.
REQ-035 Three channels all valid every cycle with cfg_dly=4 each:
- Grants rotate 0,1,2,0...
- Each channel outputs its own sample k-4 on its 5th and later grants.
- No cross-channel data ever appears.
REQ-036 cfg_dly=0 on ch1: behaves as delay 1, so the second accepted sample outputs the first.
REQ-037 Config write to ch2 while ch2 is in RUN:
- ch2 is not granted that cycle.
- fill_busy[2] rises.
- No ch2 outputs for the next cfg_dly samples.
- ch0 and ch1 outputs continue uninterrupted.
REQ-038 Wrap-around: cfg_dly=127 on ch0 streaming 300 samples; every output equals input-127 across the pointer wrap at 128 and 256.
REQ-039 Reset asserted mid-stream: the next cycle shows out_valid=0 and fill_busy=3'b111; after release, ch0 needs 104 samples again before its first output.
